// File: rtl/mult_operand_scheduler_if.sv
// Signal bundle between the operand scheduler, its producer, the sequential
// multiplier and the result consumer.
interface mult_operand_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Both in_* and out_* ports are valid/ready: a transfer happens on a rising
  // clk edge where valid && ready, and the sender holds its data stable while
  // valid is high and ready is low.
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_valid;
  logic               in_ready;

  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_load;
  logic [2*WIDTH-1:0] mul_p;
  logic               mul_valid;

  logic [2*WIDTH-1:0] out_p;
  logic [WIDTH-1:0]   out_a;
  logic [WIDTH-1:0]   out_b;
  logic               out_valid;
  logic               out_ready;

  logic [CW-1:0]      fifo_count;
  logic               timeout_err;
  logic [2:0]         dbg_state;

  // Environment side: producer, multiplier and consumer.
  modport master (
    output in_a, in_b, in_valid, mul_p, mul_valid, out_ready,
    input  in_ready, mul_a, mul_b, mul_load, out_p, out_a, out_b, out_valid,
           fifo_count, timeout_err, dbg_state
  );

  // Scheduler side.
  modport slave (
    input  in_a, in_b, in_valid, mul_p, mul_valid, out_ready,
    output in_ready, mul_a, mul_b, mul_load, out_p, out_a, out_b, out_valid,
           fifo_count, timeout_err, dbg_state
  );
endinterface

// File: rtl/mult_operand_scheduler.sv
// Operand FIFO plus issue/settle/wait/hold sequencer in front of a multi-cycle
// multiplier; one operation is outstanding at a time.
module mult_operand_scheduler #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 32
) (
  input logic                      clk,
  input logic                      rst,
  mult_operand_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [SW-1:0]      settle_cnt;
  logic [TW-1:0]      wait_cnt;
  logic               in_ready_c;
  logic               push;
  logic               pop;

  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic               mul_load_q;
  logic [2*WIDTH-1:0] out_p_q;
  logic [WIDTH-1:0]   out_a_q;
  logic [WIDTH-1:0]   out_b_q;
  logic               out_valid_q;
  logic               timeout_err_q;

  // Gated by rst so every output reads 0 while reset is held.
  assign in_ready_c = !rst && (count < CW'(DEPTH));
  assign push       = bus.in_valid && in_ready_c;
  assign pop        = (state == S_IDLE) && (count != '0);

  assign bus.in_ready    = in_ready_c;
  assign bus.fifo_count  = count;
  assign bus.dbg_state   = state;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.mul_load    = mul_load_q;
  assign bus.out_p       = out_p_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_b       = out_b_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.timeout_err = timeout_err_q;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      wait_cnt      <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_load_q    <= 1'b0;
      out_p_q       <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {mul_a_q, mul_b_q} <= mem[rd_ptr];
            mul_load_q         <= 1'b1;
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_load_q <= 1'b0;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        // mul_valid may still be high from the previous result here; ignore it.
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_WAIT: begin
          if (bus.mul_valid) begin
            out_p_q     <= bus.mul_p;
            out_a_q     <= mul_a_q;
            out_b_q     <= mul_b_q;
            out_valid_q <= 1'b1;
            state       <= S_HOLD;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          mul_load_q <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_operand_scheduler.sv
// Directed bench for mult_operand_scheduler with a behavioural multiplier and
// an expected-result queue checked on every output handshake.
module tb_mult_operand_scheduler;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 32;

  logic clk;
  logic rst;

  mult_operand_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mult_operand_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  int          mode;
  int          cyc;
  int          load_cnt;
  int          last_load;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Multiplier model: mode 0 valid 8 cycles after load, held until next load;
  // mode 1 never valid; mode 2 keeps the old valid through ISSUE/SETTLE, drops
  // it, then presents the new product.
  initial begin
    int k;
    k = 99;
    bus.mul_valid = 1'b0;
    bus.mul_p     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 99;
        bus.mul_valid = 1'b0;
        bus.mul_p     = '0;
      end else begin
        if (bus.mul_load) begin
          k = 0;
          if (mode != 2) bus.mul_valid = 1'b0;
        end else if (k < 99) begin
          k++;
        end
        case (mode)
          0: if (k == 8) begin
               bus.mul_valid = 1'b1;
               bus.mul_p     = {8'd0, bus.mul_a} * {8'd0, bus.mul_b};
             end
          1: bus.mul_valid = 1'b0;
          default: begin
            if (k == SETTLE + 1) begin
              bus.mul_valid = 1'b0;
            end else if (k == SETTLE + 3) begin
              bus.mul_valid = 1'b1;
              bus.mul_p     = {8'd0, bus.mul_a} * {8'd0, bus.mul_b};
            end
          end
        endcase
      end
    end
  end

  // Scoreboard and load monitor, sampled 1 time unit after the falling edge.
  initial begin
    logic        held;
    logic [31:0] held_v;
    logic        prev_load;
    logic [31:0] e;
    held = 1'b0;
    held_v = '0;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        held = 1'b0;
        prev_load = 1'b0;
      end else begin
        if (held) begin
          check("hold_stable", {bus.out_a, bus.out_b, bus.out_p}, held_v);
          check("hold_valid", 32'(bus.out_valid), 1);
        end
        held   = bus.out_valid && !bus.out_ready;
        held_v = {bus.out_a, bus.out_b, bus.out_p};
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(bus.out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("out_a", 32'(bus.out_a), 32'(e[31:24]));
            check("out_b", 32'(bus.out_b), 32'(e[23:16]));
            check("out_p", 32'(bus.out_p), 32'(e[15:0]));
          end
        end
        if (bus.mul_load) begin
          check("load_single_cycle", 32'(prev_load), 0);
          if (load_cnt > 0) check("load_spacing", 32'(cyc - last_load >= SETTLE + 3), 1);
          load_cnt++;
          last_load = cyc;
        end
        prev_load = bus.mul_load;
      end
    end
  end

  // Driver tasks (called on a falling edge, return on a falling edge)
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    check("push_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_load(input int max);
    for (int i = 0; i < max && !bus.mul_load; i++) @(negedge clk);
    check("wait_load", 32'(bus.mul_load), 1);
  endtask

  task automatic wait_out_valid(input int max, output int n);
    n = 0;
    for (int i = 0; i < max && !bus.out_valid; i++) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", 32'(bus.out_valid), 1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    logic saw;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    load_cnt = 0;
    last_load = -100;
    mode = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_mul", {15'd0, bus.mul_load, bus.mul_a, bus.mul_b}, 0);
    check("rst_out", {bus.out_a, bus.out_b, bus.out_p}, 0);
    check("rst_flags", {28'd0, bus.out_valid, bus.timeout_err, bus.dbg_state == 3'd0, 1'b0}, 2);
    check("rst_count", 32'(bus.fifo_count), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_count", 32'(bus.fifo_count), 0);

    // Single op, held by out_ready=0
    push(8'd255, 8'd255);
    exp_q.push_back({8'd255, 8'd255, 16'd65025});
    wait_load(10);
    wait_out_valid(40, n);
    check("single_latency", 32'(n), 9);
    check("single_p", 32'(bus.out_p), 65025);
    check("single_a", 32'(bus.out_a), 255);
    check("single_b", 32'(bus.out_b), 255);

    // Burst fills the FIFO while the first result is held
    push(8'd128, 8'd0);
    push(8'd128, 8'd1);
    push(8'd25,  8'd5);
    push(8'd11,  8'd33);
    check("full_count", 32'(bus.fifo_count), 4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_a = 8'd9;
    bus.in_b = 8'd9;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("full_refused", 32'(bus.fifo_count), 4);
    check("single_one_load", 32'(load_cnt), 1);
    check("single_still_valid", 32'(bus.out_valid), 1);
    check("single_still_p", 32'(bus.out_p), 65025);
    exp_q.push_back({8'd128, 8'd0,  16'd0});
    exp_q.push_back({8'd128, 8'd1,  16'd128});
    exp_q.push_back({8'd25,  8'd5,  16'd125});
    exp_q.push_back({8'd11,  8'd33, 16'd363});
    bus.out_ready = 1'b1;
    wait_drain(400);
    check("burst_loads", 32'(load_cnt), 5);
    check("burst_empty", 32'(bus.fifo_count), 0);

    // Backpressure
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    push(8'd80, 8'd10);
    push(8'd36, 8'd36);
    exp_q.push_back({8'd80, 8'd10, 16'd800});
    exp_q.push_back({8'd36, 8'd36, 16'd1296});
    wait_out_valid(60, n);
    check("bp_first_p", 32'(bus.out_p), 800);
    repeat (20) @(negedge clk);
    check("bp_held_p", 32'(bus.out_p), 800);
    check("bp_held_valid", 32'(bus.out_valid), 1);
    check("bp_no_second_load", 32'(load_cnt), 6);
    check("bp_queued", 32'(bus.fifo_count), 1);
    bus.out_ready = 1'b1;
    wait_drain(100);
    check("bp_loads", 32'(load_cnt), 7);

    // Stale valid carried over from the previous result
    repeat (3) @(negedge clk);
    mode = 2;
    push(8'd64, 8'd64);
    exp_q.push_back({8'd64, 8'd64, 16'd4096});
    wait_out_valid(60, n);
    check("stale_p", 32'(bus.out_p), 4096);
    wait_drain(50);
    check("stale_loads", 32'(load_cnt), 8);

    // Timeout, then the next queued op still issues
    repeat (3) @(negedge clk);
    mode = 1;
    push(8'd7, 8'd9);
    push(8'd3, 8'd4);
    exp_q.push_back({8'd3, 8'd4, 16'd12});
    wait_load(10);
    n = 0;
    saw = 1'b0;
    for (int i = 0; i < 60 && !bus.timeout_err; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) saw = 1'b1;
    end
    check("timeout_latency", 32'(n), 1 + SETTLE + TIMEOUT);
    check("timeout_no_out", 32'(saw), 0);
    mode = 0;
    wait_drain(60);
    check("timeout_sticky", 32'(bus.timeout_err), 1);
    check("timeout_loads", 32'(load_cnt), 10);

    // Reset while waiting with three entries queued
    repeat (3) @(negedge clk);
    mode = 1;
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    for (int i = 0; i < 20 && bus.dbg_state != 3'd3; i++) @(negedge clk);
    check("mid_reach_wait", 32'(bus.dbg_state), 3);
    check("mid_queued", 32'(bus.fifo_count), 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mul", {15'd0, bus.mul_load, bus.mul_a, bus.mul_b}, 0);
    check("mid_rst_out", {bus.out_a, bus.out_b, bus.out_p}, 0);
    check("mid_rst_flags", {29'd0, bus.out_valid, bus.timeout_err, bus.in_ready}, 0);
    check("mid_rst_count", 32'(bus.fifo_count), 0);
    check("mid_rst_state", 32'(bus.dbg_state), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    @(negedge clk);
    check("after_rst_count", 32'(bus.fifo_count), 0);
    check("after_rst_in_ready", 32'(bus.in_ready), 1);
    check("after_rst_valid", 32'(bus.out_valid), 0);
    push(8'd255, 8'd255);
    exp_q.push_back({8'd255, 8'd255, 16'd65025});
    wait_drain(60);
    repeat (10) @(negedge clk);
    check("after_rst_loads", 32'(load_cnt), 12);
    check("after_rst_empty", 32'(bus.fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_operand_scheduler.md
Name: mult_operand_scheduler

Overview:
- Upstream feeder and result collector for the 8x8 sequential multiplier.
- Buffers operand pairs in a small FIFO and issues them one at a time as a one-cycle `load` pulse with stable `a`/`b`.
- Waits for the multiplier's `valid`, captures the 16-bit product with its operands, and presents it on a valid/ready output port.
- Isolates producers and consumers from the multiplier's multi-cycle latency.

Parameters:
- WIDTH, 8: operand width; product width is 2*WIDTH.
- DEPTH, 4: operand FIFO entries (power of two, >=2).
- SETTLE, 2: cycles after `mul_load` during which `mul_valid` is ignored.
- TIMEOUT, 32: maximum cycles in WAIT before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset; shared with the multiplier.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- mul_a  out  WIDTH  registered operand A to the multiplier.
- mul_b  out  WIDTH  registered operand B to the multiplier.
- mul_load  out  1  one-cycle start pulse to the multiplier.
- mul_p  in  2*WIDTH  multiplier product.
- mul_valid  in  1  multiplier result valid.
- out_p  out  2*WIDTH  captured product.
- out_a  out  WIDTH  operand A of that product.
- out_b  out  WIDTH  operand B of that product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- timeout_err  out  1  sticky: a multiply timed out.

Behaviour:
- Reset values, all immediate on rst:
  - Every output is 0.
  - FIFO empty, FSM in IDLE, all counters 0.
  - `in_ready` is 1 once rst deasserts.
- Reset mid-operation: an in-flight operation and all FIFO contents are discarded; no partial output.
- FIFO push when `in_valid && in_ready`.
- FIFO pop only on the IDLE->ISSUE transition.
- Simultaneous push and pop when full: `in_ready` is 0 because it is combinational on count, so the push is refused that cycle.
- Simultaneous push and pop when not full: count is unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, pop into `mul_a`/`mul_b` and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - `mul_load`=1 for exactly this cycle; `mul_a`/`mul_b` are stable.
    - Next state is SETTLE with the settle counter = 0.
  - SETTLE:
    - `mul_valid` is ignored.
    - After SETTLE cycles, go to WAIT with the timeout counter = 0.
  - WAIT:
    - If `mul_valid`=1: register `mul_p`→`out_p` and `mul_a`/`mul_b`→`out_a`/`out_b`, set `out_valid`=1, go to HOLD.
    - Else if the timeout counter = TIMEOUT-1: set `timeout_err`=1, drop the operation, go to IDLE.
    - Else increment the timeout counter.
  - HOLD:
    - `out_*` are held stable while `out_valid`=1.
    - When `out_valid && out_ready`: clear `out_valid` next cycle, go to IDLE.
- `mul_a`/`mul_b` are held from ISSUE until the next pop; they do not change during SETTLE or WAIT.
- Only one operation is outstanding at a time. `mul_load` never asserts outside ISSUE.
- Minimum issue-to-output latency: 1 (ISSUE) + SETTLE + 1 (WAIT capture) cycles, plus the multiplier's own latency.
- Back-to-back minimum spacing between `mul_load` pulses: ISSUE, SETTLE cycles, WAIT >=1, HOLD >=1, IDLE 1.
- Product is taken from `mul_p` unmodified. No arithmetic is performed in this block.
- `timeout_err` clears only on rst.
- `in_valid` while rst=1 is ignored.

Test Plan:
- Single op: push (255,255); multiplier drives valid 8 cycles after load -> exactly one `mul_load` pulse; `out_p`=65025, `out_a`=255, `out_b`=255; `out_valid` holds until `out_ready`.
- Burst: push (128,0), (128,1), (25,5), (11,33) on consecutive cycles with `out_ready`=1:
  - `fifo_count` reaches 4 and `in_ready`=0 at full.
  - Outputs appear in order: 0, 128, 125, 363.
  - `mul_load` pulses are separated by >=SETTLE+3 cycles.
- Backpressure: push (80,10) and (36,36) with `out_ready`=0 for 20 cycles -> `out_p`=800 is held stable; no second `mul_load` until the handshake; then `out_p`=1296.
- Stale valid: `mul_valid` held 1 from the previous op through ISSUE and SETTLE, then dropped, then reasserted with `mul_p`=4096 for (64,64) -> the capture is 4096, not the stale value.
- Timeout: the multiplier model never asserts valid -> `timeout_err`=1 exactly 1+SETTLE+TIMEOUT cycles after `mul_load`; no `out_valid`; the next queued op still issues.
- Reset mid-WAIT with 3 entries queued -> all outputs 0, `fifo_count`=0, `out_valid`=0; a fresh push of (255,255) after reset yields 65025.
